// File: rtl/ex_issue_sched.sv
// EX-stage issue scheduler: accepts one decoded op per cycle, drives the
// one-hot result-register selects, sequences the fixed-latency MUL unit and
// the handshaked load unit, and keeps the shared write-back port to at most
// one write per cycle.
module ex_issue_sched #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [2:0]      issue_op_i,
    input  logic [RD_W-1:0] issue_rd_i,
    input  logic            flush_i,
    output logic            mul_start_o,
    output logic            ld_req_o,
    input  logic            ld_ack_i,
    output logic            ctrl_addsub_o,
    output logic            ctrl_mul_o,
    output logic            ctrl_shift_o,
    output logic            ctrl_logic_o,
    output logic            ctrl_ld_o,
    output logic            ctrl_br_o,
    output logic            wb_valid_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            illegal_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        OP_ADDSUB = 3'd0,
        OP_MUL    = 3'd1,
        OP_SHIFT  = 3'd2,
        OP_LOGIC  = 3'd3,
        OP_LD     = 3'd4,
        OP_BR     = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_LD_WAIT = 1'b1
    } state_e;

    // The counter holds the cycles left until the MUL write slot; it reaches 1
    // in the slot (MUL_LAT-1 cycles after the start pulse) and the write-back
    // follows one cycle later, MUL_LAT cycles after the start pulse.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_e          state_q, state_d;
    logic [3:0]      mul_cnt_q, mul_cnt_d;
    logic [RD_W-1:0] mul_rd_q, mul_rd_d;
    logic [RD_W-1:0] ld_rd_q, ld_rd_d;
    logic            ld_kill_q, ld_kill_d;
    logic            ld_req_q, ld_req_d;
    logic            wb_valid_q, wb_valid_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;

    op_e  op;
    logic is_single;
    logic is_mul;
    logic is_ld;
    logic is_illegal;
    logic mul_busy;
    logic mul_slot;
    logic ld_wait;
    logic op_gate;
    logic accept;
    logic ld_hit;

    assign op         = op_e'(issue_op_i);
    assign is_single  = (op == OP_ADDSUB) || (op == OP_SHIFT) ||
                        (op == OP_LOGIC)  || (op == OP_BR);
    assign is_mul     = (op == OP_MUL);
    assign is_ld      = (op == OP_LD);
    assign is_illegal = (op == OP_ILL6) || (op == OP_ILL7);
    assign mul_busy   = (mul_cnt_q != 4'd0);
    assign mul_slot   = (mul_cnt_q == 4'd1);
    assign ld_wait    = (state_q == S_LD_WAIT);

    // Per-op issue gate: MUL/LD need the MUL unit idle; single-cycle ops only
    // wait when they would overtake an in-flight MUL to the same register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op_gate = 1'b1;
        if (is_mul || is_ld) begin
            op_gate = !mul_busy;
        end else if (is_single) begin
            op_gate = !(mul_busy && (issue_rd_i == mul_rd_q));
        end
    end

    assign issue_ready_o = !rst && !flush_i && !ld_wait && !mul_slot && op_gate;
    assign accept        = issue_valid_i && issue_ready_o;

    // A load result is bypassed straight onto the port in the ack cycle unless
    // the load was killed by a flush (earlier, or in this very cycle).
    assign ld_hit = ld_wait && ld_ack_i && !ld_kill_q && !flush_i && !rst;

    assign ctrl_addsub_o = accept && (op == OP_ADDSUB);
    assign ctrl_shift_o  = accept && (op == OP_SHIFT);
    assign ctrl_logic_o  = accept && (op == OP_LOGIC);
    assign ctrl_br_o     = accept && (op == OP_BR);
    assign ctrl_mul_o    = mul_slot && !flush_i && !rst;
    assign ctrl_ld_o     = ld_hit;
    assign mul_start_o   = accept && is_mul;
    assign illegal_o     = accept && is_illegal;
    assign ld_req_o      = ld_req_q;
    assign wb_valid_o    = wb_valid_q || ld_hit;
    assign wb_rd_o       = ld_hit ? ld_rd_q : wb_rd_q;
    assign busy_o        = mul_busy || ld_wait;

    // MUL countdown and the registered write-back of single-cycle ops and MUL.
    always_comb begin
        mul_cnt_d  = mul_cnt_q;
        mul_rd_d   = mul_rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;

        if (flush_i) begin
            mul_cnt_d = 4'd0;
        end else if (accept && is_mul) begin
            mul_cnt_d = MUL_LOAD;
            mul_rd_d  = issue_rd_i;
        end else if (mul_busy) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end

        // The reserved slot guarantees a single-cycle op and the MUL never
        // compete for the same write-back cycle.
        if (mul_slot) begin
            wb_valid_d = !flush_i;
            wb_rd_d    = mul_rd_q;
        end else if (accept && is_single) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = issue_rd_i;
        end
    end

    // Load FSM: IDLE issues the request, LD_WAIT holds it until the ack.
    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_kill_d = ld_kill_q;
        ld_req_d  = ld_req_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && is_ld) begin
                    state_d   = S_LD_WAIT;
                    ld_req_d  = 1'b1;
                    ld_rd_d   = issue_rd_i;
                    ld_kill_d = 1'b0;
                end
            end
            S_LD_WAIT: begin
                if (ld_ack_i) begin
                    state_d   = S_IDLE;
                    ld_req_d  = 1'b0;
                    ld_kill_d = 1'b0;
                end else if (flush_i) begin
                    // The request stays up until the memory side answers; the
                    // answer is then consumed without a write-back.
                    ld_kill_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons all work at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            mul_cnt_q  <= 4'd0;
            mul_rd_q   <= '0;
            ld_rd_q    <= '0;
            ld_kill_q  <= 1'b0;
            ld_req_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            mul_rd_q   <= mul_rd_d;
            ld_rd_q    <= ld_rd_d;
            ld_kill_q  <= ld_kill_d;
            ld_req_q   <= ld_req_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

endmodule

// File: tb/tb_ex_issue_sched.sv
// Self-checking bench for ex_issue_sched: directed scenarios with fixed
// expectations, then randomized traffic against a time-stamped reference model.
module tb_ex_issue_sched;

    localparam int MUL_LAT = 3;
    localparam int RD_W    = 5;

    localparam logic [2:0] OP_ADDSUB = 3'd0;
    localparam logic [2:0] OP_MUL    = 3'd1;
    localparam logic [2:0] OP_SHIFT  = 3'd2;
    localparam logic [2:0] OP_LOGIC  = 3'd3;
    localparam logic [2:0] OP_LD     = 3'd4;
    localparam logic [2:0] OP_BR     = 3'd5;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [2:0]      issue_op_i;
    logic [RD_W-1:0] issue_rd_i;
    logic            flush_i;
    logic            mul_start_o;
    logic            ld_req_o;
    logic            ld_ack_i;
    logic            ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o;
    logic            ctrl_logic_o, ctrl_ld_o, ctrl_br_o;
    logic            wb_valid_o;
    logic [RD_W-1:0] wb_rd_o;
    logic            illegal_o;
    logic            busy_o;

    always #5 clk = ~clk;

    ex_issue_sched #(.MUL_LAT(MUL_LAT), .RD_W(RD_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_op_i    (issue_op_i),
        .issue_rd_i    (issue_rd_i),
        .flush_i       (flush_i),
        .mul_start_o   (mul_start_o),
        .ld_req_o      (ld_req_o),
        .ld_ack_i      (ld_ack_i),
        .ctrl_addsub_o (ctrl_addsub_o),
        .ctrl_mul_o    (ctrl_mul_o),
        .ctrl_shift_o  (ctrl_shift_o),
        .ctrl_logic_o  (ctrl_logic_o),
        .ctrl_ld_o     (ctrl_ld_o),
        .ctrl_br_o     (ctrl_br_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .illegal_o     (illegal_o),
        .busy_o        (busy_o)
    );

    // Snapshot of DUT outputs taken mid-cycle; ctrl bit i is the select of op code i.
    typedef struct packed {
        logic            ready;
        logic [5:0]      ctrl;
        logic            start;
        logic            ldreq;
        logic            wbv;
        logic [RD_W-1:0] wbrd;
        logic            ill;
        logic            busy;
    } obs_t;

    obs_t obs;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   last_acc;

    // Reference model: absolute cycle stamps instead of counters.
    int              cyc = 0;
    bit              mul_live = 0;
    int              mul_acc = 0;
    logic [RD_W-1:0] mul_dest = '0;
    bit              ld_pend = 0;
    bit              ld_killed = 0;
    logic [RD_W-1:0] ld_dest = '0;
    bit              sched_wb = 0;
    logic [RD_W-1:0] sched_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, compare with
    // the model, advance the model, and return just after the next rising edge.
    task automatic step(input bit v, input logic [2:0] op, input logic [RD_W-1:0] rd,
                        input bit fl = 0, input bit ack = 0, input bit r = 0);
        bit         in_flight, slot, is_mul, is_ld, is_single, is_ill, gate;
        bit         e_ready, acc, ld_fire, e_wbv;
        logic [5:0] e_ctrl;
        logic [RD_W-1:0] e_wbrd;

        rst           = r;
        issue_valid_i = v;
        issue_op_i    = op;
        issue_rd_i    = rd;
        flush_i       = fl;
        ld_ack_i      = ack;
        @(negedge clk);
        obs = '{ready: issue_ready_o,
                ctrl: {ctrl_br_o, ctrl_ld_o, ctrl_logic_o, ctrl_shift_o, ctrl_mul_o, ctrl_addsub_o},
                start: mul_start_o, ldreq: ld_req_o, wbv: wb_valid_o, wbrd: wb_rd_o,
                ill: illegal_o, busy: busy_o};

        // A MUL accepted at cycle A occupies the unit in cycles A+1 .. A+LAT-1,
        // with its write slot in the last of those.
        in_flight = mul_live && (cyc > mul_acc) && (cyc <= mul_acc + MUL_LAT - 1);
        slot      = mul_live && (cyc == mul_acc + MUL_LAT - 1);
        is_mul    = (op == OP_MUL);
        is_ld     = (op == OP_LD);
        is_single = (op == OP_ADDSUB) || (op == OP_SHIFT) || (op == OP_LOGIC) || (op == OP_BR);
        is_ill    = (op >= 3'd6);
        if (is_mul || is_ld)  gate = !in_flight;
        else if (is_single)   gate = !(in_flight && rd == mul_dest);
        else                  gate = 1'b1;
        e_ready = !r && !fl && !ld_pend && !slot && gate;
        acc     = v && e_ready;
        ld_fire = ld_pend && ack && !ld_killed && !fl && !r;
        e_ctrl  = '0;
        if (acc && is_single)   e_ctrl[op] = 1'b1;
        if (slot && !fl && !r)  e_ctrl[1]  = 1'b1;
        if (ld_fire)            e_ctrl[4]  = 1'b1;
        e_wbv  = sched_wb || ld_fire;
        e_wbrd = ld_fire ? ld_dest : sched_rd;

        check("ready",     32'(obs.ready), 32'(e_ready));
        check("ctrl",      32'(obs.ctrl),  32'(e_ctrl));
        check("mul_start", 32'(obs.start), 32'(acc && is_mul));
        check("ld_req",    32'(obs.ldreq), 32'(ld_pend));
        check("wb_valid",  32'(obs.wbv),   32'(e_wbv));
        if (e_wbv) check("wb_rd", 32'(obs.wbrd), 32'(e_wbrd));
        check("illegal",   32'(obs.ill),   32'(acc && is_ill));
        check("busy",      32'(obs.busy),  32'(in_flight || ld_pend));

        if (r) begin
            mul_live  = 0;
            ld_pend   = 0;
            ld_killed = 0;
            sched_wb  = 0;
            sched_rd  = '0;
        end else begin
            sched_wb = !fl && ((acc && is_single) || slot);
            if (slot)                   sched_rd = mul_dest;
            else if (acc && is_single)  sched_rd = rd;
            if (fl) mul_live = 0;
            if (acc && is_mul) begin
                mul_live = 1;
                mul_acc  = cyc;
                mul_dest = rd;
            end
            if (ld_pend) begin
                if (ack) begin
                    ld_pend   = 0;
                    ld_killed = 0;
                end else if (fl) begin
                    ld_killed = 1;
                end
            end
            if (acc && is_ld) begin
                ld_pend   = 1;
                ld_dest   = rd;
                ld_killed = 0;
            end
        end
        last_acc = acc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_req;
        bit hv;
        logic [2:0] hop;
        logic [RD_W-1:0] hrd;

        rst = 1'b1; issue_valid_i = 1'b0; issue_op_i = '0; issue_rd_i = '0;
        flush_i = 1'b0; ld_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: nothing accepted, all outputs low, wb_rd cleared.
        step(1, OP_ADDSUB, 5'd3, 0, 0, 1);
        check("rst_ready", 32'(obs.ready), 32'd0);
        check("rst_outs", 32'({obs.ctrl, obs.start, obs.ldreq, obs.wbv, obs.ill, obs.busy}), 32'd0);
        check("rst_wb_rd", 32'(obs.wbrd), 32'd0);

        // addsub rd=3: select in the accept cycle, write-back one cycle later.
        step(1, OP_ADDSUB, 5'd3);
        check("t1_ctrl", 32'(obs.ctrl), 32'b000001);
        step(0, OP_ADDSUB, 5'd0);
        check("t1_wb", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd3}));

        // mul rd=5 then shift rd=6 under the mul, then addsub blocked by the slot.
        step(1, OP_MUL, 5'd5);
        check("t2_start", 32'(obs.start), 32'd1);
        step(1, OP_SHIFT, 5'd6);
        check("t2_shift", 32'({obs.ready, obs.ctrl}), 32'({1'b1, 6'b000100}));
        step(1, OP_ADDSUB, 5'd8);
        check("t2_slot", 32'({obs.ready, obs.ctrl}), 32'({1'b0, 6'b000010}));
        check("t2_wb_shift", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd6}));
        step(1, OP_ADDSUB, 5'd8);
        check("t2_wb_mul", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd5}));
        check("t2_addsub", 32'(obs.ctrl), 32'b000001);
        step(0, OP_ADDSUB, 5'd0);
        check("t2_wb_add", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd8}));

        // WAW: logic rd=7 waits for the in-flight mul rd=7.
        step(1, OP_MUL, 5'd7);
        step(1, OP_LOGIC, 5'd7);
        check("t3_block1", 32'(obs.ready), 32'd0);
        step(1, OP_LOGIC, 5'd7);
        check("t3_block2", 32'(obs.ready), 32'd0);
        step(1, OP_LOGIC, 5'd7);
        check("t3_accept", 32'({obs.ready, obs.ctrl}), 32'({1'b1, 6'b001000}));
        check("t3_wb_mul", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd7}));
        step(0, OP_ADDSUB, 5'd0);
        check("t3_wb_logic", 32'({obs.wbv, obs.wbrd}), 32'({1'b1, 5'd7}));

        // ld rd=9 acked 4 cycles after accept; no issue meanwhile.
        step(1, OP_LD, 5'd9);
        check("t4_accept", 32'({obs.ready, obs.ctrl}), 32'({1'b1, 6'b000000}));
        n_req = 0;
        repeat (3) begin
            step(1, OP_ADDSUB, 5'd1);
            check("t4_wait", 32'({obs.ready, obs.wbv}), 32'd0);
            n_req += int'(obs.ldreq);
        end
        step(1, OP_ADDSUB, 5'd1, 0, 1);
        check("t4_ack", 32'({obs.ctrl, obs.wbv, obs.wbrd}), 32'({6'b010000, 1'b1, 5'd9}));
        n_req += int'(obs.ldreq);
        check("t4_req_cycles", 32'(n_req), 32'd4);
        step(1, OP_ADDSUB, 5'd1);
        check("t4_after", 32'({obs.ready, obs.ldreq, obs.busy}), 32'b100);
        step(0, OP_ADDSUB, 5'd0);

        // Flush at mul_cnt==2 kills the mul.
        step(1, OP_MUL, 5'd4);
        step(0, OP_ADDSUB, 5'd0, 1);
        check("t5_flush_ctrl", 32'(obs.ctrl), 32'd0);
        step(0, OP_ADDSUB, 5'd0);
        check("t5_flush_next", 32'({obs.busy, obs.ctrl, obs.wbv}), 32'd0);
        step(0, OP_ADDSUB, 5'd0);
        check("t5_flush_late", 32'({obs.ctrl, obs.wbv}), 32'd0);

        // Flush in LD_WAIT: the ack is consumed silently.
        step(1, OP_LD, 5'd10);
        step(0, OP_ADDSUB, 5'd0, 1);
        check("t5_ld_req_kept", 32'(obs.ldreq), 32'd1);
        step(0, OP_ADDSUB, 5'd0, 0, 1);
        check("t5_ld_silent", 32'({obs.ctrl, obs.wbv}), 32'd0);
        step(0, OP_ADDSUB, 5'd0);
        check("t5_ld_done", 32'({obs.busy, obs.ldreq}), 32'd0);

        // Illegal op and a stray ack outside LD_WAIT.
        step(1, 3'd7, 5'd1);
        check("t6_illegal", 32'({obs.ready, obs.ill, obs.ctrl}), 32'({1'b1, 1'b1, 6'b0}));
        step(0, OP_ADDSUB, 5'd0, 0, 1);
        check("t6_no_wb", 32'({obs.wbv, obs.ill, obs.ctrl}), 32'd0);

        // Reset mid-mul: everything quiet afterwards.
        step(1, OP_MUL, 5'd2);
        step(0, OP_ADDSUB, 5'd0, 0, 0, 1);
        step(0, OP_ADDSUB, 5'd0);
        check("t6_rst_outs", 32'({obs.ctrl, obs.wbv, obs.busy, obs.ldreq, obs.start, obs.ill}), 32'd0);
        repeat (3) begin
            step(0, OP_ADDSUB, 5'd0);
            check("t6_rst_no_mul", 32'(obs.ctrl), 32'd0);
        end

        // Randomized traffic; an offered op is held until accepted.
        hv = 0; hop = '0; hrd = '0;
        for (int i = 0; i < 4000; i++) begin
            bit v, f, a, r;
            logic [2:0] op;
            logic [RD_W-1:0] rd;
            if (hv) begin
                v = 1; op = hop; rd = hrd;
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                op = 3'($urandom_range(0, 7));
                rd = RD_W'($urandom_range(0, 3));
            end
            f = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(v, op, rd, f, a, r);
            hv  = v && !last_acc && !r;
            hop = op;
            hrd = rd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
